// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the fetch controller: default sizing, PC step and FSM state codes.
package fetch_ctrl_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int unsigned PC_STEP      = 4;
  localparam int unsigned CNT_W        = 32;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_REQ  = 2'd0;
  localparam logic [ST_W-1:0] ST_WAIT = 2'd1;
  localparam logic [ST_W-1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bundle: imem request/response, execute redirect and IFU handoff.
interface fetch_ctrl_if #(
  parameter int unsigned XLEN = fetch_ctrl_pkg::XLEN_DEF
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            imem_rsp_err;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] mem_data;
  logic            out_valid;
  logic            out_ready;
  logic            fetch_fault;
  logic [31:0]     fetch_cnt;

  modport master (
    output imem_req_valid, imem_req_addr, pc, mem_data, out_valid, fetch_fault, fetch_cnt,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
           redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, pc, mem_data, out_valid, fetch_fault, fetch_cnt,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
           redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, issues one imem read at a time and hands the word to the IFU.
// Redirects from execute discard any in-flight or held fetch.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  fetch_ctrl_if.master  bus
);

  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [ST_W-1:0]  state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             fault_q, fault_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and handoff registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      data_q  <= '0;
      fault_q <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      fault_q <= fault_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: normal progression first, redirect overrides it last
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    data_d  = data_q;
    fault_d = fault_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_REQ: begin
        if (bus.imem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            data_d  = bus.imem_rsp_data;
            fault_d = bus.imem_rsp_err;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          pc_d    = pc_q + STEP;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    if (bus.redirect_valid) begin
      pc_d  = bus.redirect_pc & ALIGN_MASK;
      cnt_d = cnt_q;
      case (state_q)
        ST_REQ: begin
          // an accepted request is already in flight and must be dropped on return
          if (bus.imem_req_ready) begin
            state_d = ST_WAIT;
            drop_d  = 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_valid) begin
            state_d = ST_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  // Request valid is forced low while reset is asserted
  assign bus.imem_req_valid = (state_q == ST_REQ) && !rst;
  assign bus.imem_req_addr  = pc_q;
  assign bus.out_valid      = (state_q == ST_HOLD);
  assign bus.pc             = pc_q;
  assign bus.mem_data       = data_q;
  assign bus.fetch_fault    = (state_q == ST_HOLD) && fault_q;
  assign bus.fetch_cnt      = cnt_q;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch controller sitting directly upstream of the IFU: owns the architectural PC, issues one instruction-memory read at a time over a valid/ready request channel, captures the returned word, and presents the `pc`/`mem_data` pair to the IFU with a valid/ready handoff. Accepts control-flow redirects from the execute stage and discards any in-flight or held fetch they make stale. Single outstanding request, no prefetch.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset
- XLEN, 32, address/data width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  read address (word-aligned)
- imem_rsp_valid  in  1  read data valid (one pulse per accepted request)
- imem_rsp_data  in  XLEN  read data
- imem_rsp_err  in  1  access fault, qualified by imem_rsp_valid
- redirect_valid  in  1  execute stage redirect pulse
- redirect_pc  in  XLEN  redirect target
- pc  out  XLEN  PC of held instruction, to IFU
- mem_data  out  XLEN  held instruction word, to IFU
- out_valid  out  1  pc/mem_data valid
- out_ready  in  1  IFU/decode accepts
- fetch_fault  out  1  held word came back with imem_rsp_err
- fetch_cnt  out  32  count of completed handoffs

## Operation
- States: REQ, WAIT, HOLD. Registers: pc_q, data_q, fault_q, drop_q, fetch_cnt.
- REQ: imem_req_valid=1, imem_req_addr=pc_q. On req_ready -> WAIT.
- WAIT: on imem_rsp_valid: if drop_q, clear drop_q, -> REQ (response discarded); else capture data_q/fault_q, -> HOLD.
- HOLD: out_valid=1, pc=pc_q, mem_data=data_q, fetch_fault=fault_q. On out_ready: pc_q += 4 (mod 2^XLEN, wraps), fetch_cnt += 1 (wraps), -> REQ.
- Redirect (highest priority, any state): pc_q <= {redirect_pc[XLEN-1:2],2'b00}; the sum PC+4 from HOLD is not applied and fetch_cnt does not increment.
  - REQ, not accepted: stay REQ; address changes next cycle (only permitted change of an unaccepted request).
  - REQ, accepted same cycle: -> WAIT with drop_q=1.
  - WAIT, no rsp: stay WAIT, drop_q=1. WAIT, rsp same cycle: response discarded, -> REQ.
  - HOLD (with or without out_ready): held word dropped, out_valid falls next cycle, -> REQ.
- Fault does not stop fetching; the faulted word is handed off like any other, flagged.
- imem_rsp_valid outside WAIT is ignored.

## Timing
- Reset values: state REQ, pc_q=RESET_PC, imem_req_valid=1 (first cycle after reset deassert, combinationally during reset held 0), imem_req_addr=RESET_PC, out_valid=0, pc=RESET_PC, mem_data=0, fetch_fault=0, fetch_cnt=0, drop_q=0.
- Outputs are registered-state functions only; no combinational path from any input to any output.
- Request accepted cycle N; response earliest N+1; out_valid earliest N+2.
- Handoff in cycle M; next request valid M+1. Best-case throughput: one instruction per 3 cycles.
- Reset mid-operation: immediate return to reset values; any later response for the aborted request is the memory's responsibility to suppress.

## Structure
- Shared package: state enum (REQ/WAIT/HOLD), RESET_PC default, PC_STEP=4.
- Single module; no sub-module needed. Handoff register (pc/data/fault) kept inline.

## Test plan
- Reset, req_ready=1, rsp after 1 cycle data 32'h0000_0413, out_ready=1 -> req addr 8000_0000, out_valid with pc 8000_0000/mem_data 0000_0413, next req 8000_0004, fetch_cnt=1.
- out_ready=0 for 5 cycles in HOLD -> pc/mem_data stable, no new request, fetch_cnt unchanged.
- Redirect to 8000_0102 while WAIT, rsp arrives 3 cycles later -> response dropped, next req addr 8000_0100, no out_valid for old word.
- Redirect and out_ready in same HOLD cycle -> no handoff counted, next req at redirect target.
- rsp_err=1 on fetch at 8000_0010 -> out_valid with fetch_fault=1, handoff proceeds, next req 8000_0014 with fetch_fault=0.
- pc_q=FFFF_FFFC handoff -> next req addr 0000_0000; async rst asserted mid-WAIT -> outputs at reset values same cycle.
